countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  BCD mm:ss countdown engine for the countdown display path.
//  Consumes the divided square wave produced by the frequency divider as a
//  tick source, counts TICKS_PER_SEC rising edges per second, and decrements
//  the loaded time. Signals expiry to downstream display/buzzer logic.
//  The divider and this block share one clock domain, so no synchronizer is used.
// PARAMETERS
//  TICKS_PER_SEC  1000  tick_in rising edges per elapsed second (50MHz/50000 = 1kHz)
//  PRESC_W        10    prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_SEC
// PORTS
//  clock     in   1  system clock; all logic on posedge
//  reset     in   1  asynchronous, active-high reset
//  tick_in   in   1  divided clock from frequency divider (level, same domain)
//  load      in   1  1-cycle strobe: capture load_min/load_sec
//  load_min  in   8  BCD minutes {tens,ones}, 00..99
//  load_sec  in   8  BCD seconds {tens,ones}, 00..59
//  start     in   1  1-cycle strobe: begin/resume counting
//  pause     in   1  1-cycle strobe: freeze counting
//  min_bcd   out  8  current minutes, BCD
//  sec_bcd   out  8  current seconds, BCD
//  running   out  1  high in RUN state
//  done      out  1  1-cycle pulse when count reaches 00:00
//  expired   out  1  level, high in EXPIRED state
// BEHAVIOUR
//  Reset: state IDLE; min_bcd=sec_bcd=0; prescaler=0; tick_d=0; running=done=expired=0.
//  Edge detect: tick_d <= tick_in each cycle; tick_rise = tick_in & ~tick_d.
//  FSM states: IDLE, RUN, PAUSED, EXPIRED. Strobe priority: load > pause > start.
//   any   + load  -> IDLE; time <= clamped inputs; prescaler <= 0; done stays 0.
//   IDLE  + start -> RUN if time != 00:00, else stay IDLE (no done).
//   RUN   + pause -> PAUSED; prescaler and time hold.
//   PAUSED+ start -> RUN; prescaler resumes from held value.
//   RUN   + start, PAUSED + pause, IDLE + pause: ignored.
//   EXPIRED: start/pause ignored; only load or reset exits.
//  Clamp on load: any digit > 9 -> 9; seconds tens > 5 -> 5.
//  Counting: only when registered state == RUN and tick_rise.
//   prescaler < TICKS_PER_SEC-1: prescaler + 1.
//   prescaler == TICKS_PER_SEC-1: prescaler <= 0; time decrements by 1 s.
//  BCD decrement, registered, visible the cycle after the terminal tick_rise:
//   sec ones 0 -> 9 with borrow into sec tens.
//   sec tens 0 (on borrow) -> 5 with borrow into minutes.
//   minute digits borrow the same way (ones 0 -> 9).
//   00:00 is never decremented.
//  Expiry: when the decrement yields 00:00 -> EXPIRED; done=1 for exactly that cycle.
//   running falls the same cycle; expired rises the same cycle.
//  Latency: start at cycle N -> running=1 at N+1; tick rises from N+1 are counted.
//  Simultaneous events in RUN:
//   pause + terminal tick in same cycle: pause wins; no decrement; prescaler holds.
//   load + terminal tick: load wins; loaded value shown, no decrement.
//  tick_in high at reset release counts as a rise (tick_d=0); harmless outside RUN.
//  Async reset mid-run: outputs return to reset values immediately, without a clock edge.
// TESTING (sim with TICKS_PER_SEC=4, tick_in period 10 clocks)
//  1. load 00:03, start -> 02 after 4th rise, 01 after 8th, 00 after 12th;
//     done pulses 1 cycle; expired=1; running=0.
//  2. load 01:00, run 4 rises -> 00:59; load 10:00, 4 rises -> 09:59.
//  3. load 00:05, start, 2 rises, pause, 100 clocks of ticks -> no change;
//     start, 2 more rises -> 00:04.
//  4. load min=8'hAF sec=8'h7C -> min_bcd=8'h99, sec_bcd=8'h59; start with
//     00:00 loaded -> running stays 0, done never asserts.
//  5. load+pause same cycle in RUN -> IDLE with new value; start+pause in
//     PAUSED -> stays PAUSED; pause on terminal tick -> no decrement.
//  6. assert reset between clock edges mid-run -> all outputs 0 at once;
//     after release, start ignored until a load.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control strobes, load values and status outputs of the mm:ss countdown engine.
// The driver side (tick source, control) is the master; the timer is the slave.
interface countdown_timer_if;
    logic       tick_in;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       expired;

    modport master (
        output tick_in, load, load_min, load_sec, start, pause,
        input  min_bcd, sec_bcd, running, done, expired
    );

    modport slave (
        input  tick_in, load, load_min, load_sec, start, pause,
        output min_bcd, sec_bcd, running, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown: counts TICKS_PER_SEC rising edges of tick_in per second
// and decrements the loaded time, flagging expiry at 00:00.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PRESC_W       = 10
) (
    input  logic               clock,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

    localparam logic [PRESC_W-1:0] LP_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_min, r_sec, w_min_nxt, w_sec_nxt;
    logic [PRESC_W-1:0] r_presc, w_presc_nxt;
    logic               r_tick_d;
    logic               r_done, w_done_nxt;
    logic               w_tick_rise;
    logic [15:0]        w_dec;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One-second decrement of {min,sec}; 00:00 is left untouched.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (t != 16'h0000) begin
            if (so != 4'd0) so = so - 4'd1;
            else begin
                so = 4'd9;
                if (st != 4'd0) st = st - 4'd1;
                else begin
                    st = 4'd5;
                    if (mo != 4'd0) mo = mo - 4'd1;
                    else begin
                        mo = 4'd9;
                        mt = mt - 4'd1;
                    end
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign w_tick_rise = bus.tick_in & ~r_tick_d;
    assign w_dec       = bcd_dec({r_min, r_sec});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_min    <= 8'h00;
            r_sec    <= 8'h00;
            r_presc  <= '0;
            r_tick_d <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_min    <= w_min_nxt;
            r_sec    <= w_sec_nxt;
            r_presc  <= w_presc_nxt;
            r_tick_d <= bus.tick_in;
            r_done   <= w_done_nxt;
        end
    end

    // Strobe priority load > pause > start; a pause that has no effect still masks start.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
        if (bus.load) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_min_nxt   = {clamp_digit(bus.load_min[7:4], 4'd9), clamp_digit(bus.load_min[3:0], 4'd9)};
            w_sec_nxt   = {clamp_digit(bus.load_sec[7:4], 4'd5), clamp_digit(bus.load_sec[3:0], 4'd9)};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.pause && ({r_min, r_sec} != 16'h0000))
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (bus.pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (w_tick_rise) begin
                        if (r_presc == LP_LAST) begin
                            w_presc_nxt = '0;
                            {w_min_nxt, w_sec_nxt} = w_dec;
                            if (w_dec == 16'h0000) begin
                                w_state_nxt = S_EXPIRED;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_presc_nxt = r_presc + 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (bus.start && !bus.pause)
                        w_state_nxt = S_RUN;
                end
                default: ;
            endcase
        end
    end

    assign bus.min_bcd = r_min;
    assign bus.sec_bcd = r_sec;
    assign bus.running = (r_state == S_RUN);
    assign bus.expired = (r_state == S_EXPIRED);
    assign bus.done    = r_done;

endmodule
